// File: rtl/serial_paralelo.sv
// serial_paralelo: MSB-first serial-to-parallel receiver with COM-character byte alignment.
// Optional macro SERIAL_PARALELO_COMCNT_EN adds a saturating count of idle COM bytes seen while active.
module serial_paralelo #(
   parameter logic [7:0] COM_CHAR = 8'hBC,
   parameter int         BC_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
`ifdef SERIAL_PARALELO_COMCNT_EN
   ,
   output logic [7:0] com_total
`endif
);
   localparam logic [1:0] SEARCH = 2'b00;
   localparam logic [1:0] SYNC   = 2'b01;
   localparam logic [1:0] ACTIVE = 2'b10;
   localparam logic [3:0] BC     = 4'(BC_COUNT);

   logic [1:0] state, next_state;
   logic [7:0] shift_reg;
   logic [7:0] next_byte;
   logic [2:0] bit_cnt;
   logic [3:0] com_cnt;
   logic       is_com;
   logic       last_bit;

   assign next_byte = {shift_reg[6:0], data_in};
   assign is_com    = next_byte == COM_CHAR;
   assign last_bit  = bit_cnt == 3'd7;

   // state register
   always_ff @(posedge clk_32f)
      state <= reset ? SEARCH : next_state;

   // next-state: bit hunt, then byte-aligned confirmation, then locked forever
   always_comb begin
      next_state = SEARCH;
      case (state)
         SEARCH: next_state = is_com ? ((BC == 4'd1) ? ACTIVE : SYNC) : SEARCH;
         SYNC:   next_state = !last_bit ? SYNC :
                              !is_com ? SEARCH :
                              (com_cnt + 4'd1 == BC) ? ACTIVE : SYNC;
         ACTIVE: next_state = ACTIVE;
         default: next_state = SEARCH;
      endcase
   end

   // registered datapath and outputs, updated at byte boundaries
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         com_cnt   <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         active    <= 1'b0;
`ifdef SERIAL_PARALELO_COMCNT_EN
         com_total <= '0;
`endif
      end else begin
         shift_reg <= next_byte;
         active    <= next_state == ACTIVE;
         case (state)
            SEARCH: if (is_com) begin
               bit_cnt <= '0;
               com_cnt <= 4'd1;
            end
            SYNC: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (last_bit) com_cnt <= is_com ? com_cnt + 4'd1 : 4'd0;
            end
            ACTIVE: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (last_bit) begin
                  data_out  <= next_byte;
                  valid_out <= !is_com;
`ifdef SERIAL_PARALELO_COMCNT_EN
                  if (is_com && com_total != 8'hFF) com_total <= com_total + 8'd1;
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: randomized streams checked against a scan-based lock/byte model.
module tb_serial_paralelo;
   localparam logic [7:0] COM = 8'hBC;
   localparam int         BC  = 4;

   logic       clk_32f = 1'b0;
   logic       reset = 1'b1;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
`ifdef SERIAL_PARALELO_COMCNT_EN
   logic [7:0] com_total;
`endif

   int errs = 0;
   int checks = 0;
   bit bits[$];

   serial_paralelo #(.COM_CHAR(COM), .BC_COUNT(BC)) dut (
      .clk_32f(clk_32f),
      .reset(reset),
      .data_in(data_in),
      .data_out(data_out),
      .valid_out(valid_out),
      .active(active)
`ifdef SERIAL_PARALELO_COMCNT_EN
      ,
      .com_total(com_total)
`endif
   );

   always #5 clk_32f = ~clk_32f;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int k = 7; k >= 0; k--) bits.push_back(b[k]);
   endtask

   function automatic logic [7:0] win(input int i);
      logic [7:0] w;
      w = '0;
      for (int k = i - 7; k <= i; k++) w = {w[6:0], (k >= 0) ? bits[k] : 1'b0};
      return w;
   endfunction

   // Edge index at which lock is declared: a COM found anywhere, followed by
   // BC-1 more COMs on 8-bit boundaries; a failed boundary restarts the hunt one bit later.
   function automatic int find_lock();
      int n, i, j, cnt;
      n = bits.size();
      i = 0;
      while (i < n) begin
         if (win(i) != COM) begin
            i++;
         end else begin
            j = i;
            cnt = 1;
            while (cnt < BC && j + 8 < n && win(j + 8) == COM) begin
               j += 8;
               cnt++;
            end
            if (cnt == BC) return j;
            i = (j + 8 < n) ? j + 9 : n;
         end
      end
      return -1;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         data_in = ~data_in;
         @(posedge clk_32f);
         #1;
         check("rst_data", data_out, 8'h00);
         check("rst_valid", valid_out, 0);
         check("rst_active", active, 0);
`ifdef SERIAL_PARALELO_COMCNT_EN
         check("rst_comtotal", com_total, 8'h00);
`endif
      end
      reset = 1'b0;
   endtask

   // Reset, then play the queued bits and compare every edge against the model.
   task automatic run_seg();
      int lock;
      logic [7:0] edo, ect, b;
      logic ev;
      lock = find_lock();
      edo = '0;
      ev = 1'b0;
      ect = '0;
      do_reset();
      for (int e = 0; e < bits.size(); e++) begin
         data_in = bits[e];
         @(posedge clk_32f);
         #1;
         if (lock >= 0 && e > lock && (e - lock) % 8 == 0) begin
            b = win(e);
            edo = b;
            ev = b != COM;
            if (b == COM && ect != 8'hFF) ect++;
         end
         check("active", active, (lock >= 0 && e >= lock) ? 1 : 0);
         check("data_out", data_out, edo);
         check("valid_out", valid_out, ev);
`ifdef SERIAL_PARALELO_COMCNT_EN
         check("com_total", com_total, ect);
`endif
      end
      bits.delete();
   endtask

   initial begin
      // aligned lock, then data bytes and an idle
      repeat (BC) push_byte(COM);
      push_byte(8'hFF);
      push_byte(8'h5A);
      push_byte(COM);
      repeat (6) push_byte(8'($urandom));
      run_seg();

      // misaligned start, lock attempt broken by a data byte
      bits.push_back(1'b0);
      bits.push_back(1'b1);
      bits.push_back(1'b0);
      push_byte(COM);
      push_byte(COM);
      push_byte(8'h12);
      repeat (BC) push_byte(COM);
      push_byte(8'h34);
      push_byte(COM);
      run_seg();

      // lock, then reset three bits into a byte; next segment starts with reset
      repeat (BC) push_byte(COM);
      bits.push_back(1'b1);
      bits.push_back(1'b0);
      bits.push_back(1'b1);
      run_seg();

      // random noise, partial locks and random payload
      for (int s = 0; s < 6; s++) begin
         repeat ($urandom_range(60, 1)) bits.push_back(1'($urandom));
         repeat ($urandom_range(BC + 1, 1)) push_byte(COM);
         if ($urandom_range(1, 0) != 0) push_byte(8'($urandom));
         repeat (BC) push_byte(COM);
         repeat (12) push_byte(($urandom_range(2, 0) == 0) ? COM : 8'($urandom));
         run_seg();
      end

`ifdef SERIAL_PARALELO_COMCNT_EN
      repeat (BC) push_byte(COM);
      repeat (300) push_byte(COM);
      push_byte(8'h12);
      run_seg();
      check("comtotal_sat", com_total, 8'hFF);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
